// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg
// Shared definitions for the ALU sequencing controller:
//   - datapath opcode encodings (ADD/SUB/PAR/COMP)
//   - controller state enumeration
//   - default operand width and WAIT_DONE timeout length
package alu_ctrl_pkg;

    localparam int DEFAULT_DATA_WIDTH     = 8;
    localparam int DEFAULT_TIMEOUT_CYCLES = 16;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_PAR  = 2'b10;
    localparam logic [1:0] OP_COMP = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD_A    = 3'd1,
        ST_LOAD_B    = 3'd2,
        ST_START     = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_RESP      = 3'd5
    } state_t;

endpackage

// File: rtl/alu_ctrl_timer.sv
// alu_ctrl_timer
// Counts cycles spent waiting for the datapath and flags expiry on the
// TIMEOUT_CYCLES-th waiting cycle.
// Ports:
//   clk     - rising-edge clock
//   reset   - synchronous active-high reset
//   clear   - zero the counter (asserted the cycle before waiting begins)
//   enable  - count this cycle (high while waiting)
//   expired - high during the last allowed waiting cycle
module alu_ctrl_timer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count_reg;

    // The first waiting cycle sees count 0, so count TIMEOUT_CYCLES-1 marks
    // the final allowed cycle. The counter saturates there.
    assign expired = enable && (count_reg == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count_reg <= '0;
        end else if (enable && !expired) begin
            count_reg <= count_reg + 1'b1;
        end
    end

endmodule

// File: rtl/alu_controller.sv
// alu_controller
// Sequences one ALU operation at a time: accepts a command (opcode, A, B),
// loads A then B into the datapath, pulses start, waits for alu_done,
// captures result/overflow and presents them until the requester accepts.
// Optional build macro: ALU_CTRL_TIMEOUT_EN adds a WAIT_DONE timeout that
// returns a response with rsp_error=1 after TIMEOUT_CYCLES waiting cycles.
// Ports:
//   clk, reset                      - clock, synchronous active-high reset
//   cmd_valid/cmd_ready             - command handshake
//   cmd_opcode, cmd_a, cmd_b        - command payload
//   rsp_valid/rsp_ready             - response handshake
//   rsp_result, rsp_overflow        - captured datapath outputs
//   rsp_error                       - operation aborted by timeout
//   busy                            - controller not in IDLE
//   alu_data, opcode_value          - datapath operand bus and opcode
//   store_a, store_b, start         - datapath strobes
//   alu_done, result, overflow_def  - datapath completion and outputs
module alu_controller
    import alu_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_opcode,
    input  logic [DATA_WIDTH-1:0] cmd_a,
    input  logic [DATA_WIDTH-1:0] cmd_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_result,
    output logic                  rsp_overflow,
    output logic                  rsp_error,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] alu_data,
    output logic [1:0]            opcode_value,
    output logic                  store_a,
    output logic                  store_b,
    output logic                  start,
    input  logic                  alu_done,
    input  logic [DATA_WIDTH-1:0] result,
    input  logic                  overflow_def
);

    state_t state_reg;
    state_t state_next;

    logic [1:0]            opcode_reg;
    logic [DATA_WIDTH-1:0] a_reg;
    logic [DATA_WIDTH-1:0] b_reg;
    logic [DATA_WIDTH-1:0] rsp_result_reg;
    logic                  rsp_overflow_reg;

    logic accept;
    logic capture;

    // A zero-length timeout would make WAIT_DONE abort immediately; this
    // block exists only to make that configuration stand out if it appears.
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_nonpositive
    end

`ifdef ALU_CTRL_TIMEOUT_EN
    logic timer_clear;
    logic timer_enable;
    logic timer_expired;
    logic timeout_hit;
    logic rsp_error_reg;

    alu_ctrl_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (timer_clear),
        .enable (timer_enable),
        .expired(timer_expired)
    );

    assign rsp_error = rsp_error_reg;
`else
    assign rsp_error = 1'b0;
`endif

    assign rsp_result   = rsp_result_reg;
    assign rsp_overflow = rsp_overflow_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and all outputs decode from state_reg plus registered
    // payload only; cmd_* and rsp_ready steer state_next, never outputs.
    always_comb begin
        state_next   = state_reg;
        cmd_ready    = 1'b0;
        busy         = 1'b1;
        rsp_valid    = 1'b0;
        store_a      = 1'b0;
        store_b      = 1'b0;
        start        = 1'b0;
        alu_data     = '0;
        opcode_value = 2'b00;
        accept       = 1'b0;
        capture      = 1'b0;
`ifdef ALU_CTRL_TIMEOUT_EN
        timer_clear  = 1'b0;
        timer_enable = 1'b0;
        timeout_hit  = 1'b0;
`endif
        case (state_reg)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    accept     = 1'b1;
                    state_next = ST_LOAD_A;
                end
            end
            ST_LOAD_A: begin
                store_a      = 1'b1;
                alu_data     = a_reg;
                opcode_value = opcode_reg;
                state_next   = ST_LOAD_B;
            end
            ST_LOAD_B: begin
                store_b      = 1'b1;
                alu_data     = b_reg;
                opcode_value = opcode_reg;
                state_next   = ST_START;
            end
            ST_START: begin
                start        = 1'b1;
                opcode_value = opcode_reg;
`ifdef ALU_CTRL_TIMEOUT_EN
                timer_clear  = 1'b1;
`endif
                state_next   = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                opcode_value = opcode_reg;
`ifdef ALU_CTRL_TIMEOUT_EN
                timer_enable = 1'b1;
`endif
                // alu_done has priority over a coinciding timeout.
                if (alu_done) begin
                    capture    = 1'b1;
                    state_next = ST_RESP;
                end
`ifdef ALU_CTRL_TIMEOUT_EN
                else if (timer_expired) begin
                    timeout_hit = 1'b1;
                    state_next  = ST_RESP;
                end
`endif
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Command payload and response registers. Capture happens on the same
    // edge that sees alu_done, since the datapath clears result afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            opcode_reg       <= 2'b00;
            a_reg            <= '0;
            b_reg            <= '0;
            rsp_result_reg   <= '0;
            rsp_overflow_reg <= 1'b0;
`ifdef ALU_CTRL_TIMEOUT_EN
            rsp_error_reg    <= 1'b0;
`endif
        end else begin
            if (accept) begin
                opcode_reg <= cmd_opcode;
                a_reg      <= cmd_a;
                b_reg      <= cmd_b;
            end
            if (capture) begin
                rsp_result_reg   <= result;
                rsp_overflow_reg <= overflow_def;
`ifdef ALU_CTRL_TIMEOUT_EN
                rsp_error_reg    <= 1'b0;
            end else if (timeout_hit) begin
                rsp_result_reg   <= '0;
                rsp_overflow_reg <= 1'b0;
                rsp_error_reg    <= 1'b1;
`endif
            end
        end
    end

endmodule

// File: tb/tb_alu_controller.sv
// tb_alu_controller
// Directed bench for alu_controller: strobe sequencing, capture, response
// backpressure, reset abort, spurious done pulses and (when built with
// ALU_CTRL_TIMEOUT_EN) the WAIT_DONE timeout.
module tb_alu_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_opcode;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_result;
    logic       rsp_overflow;
    logic       rsp_error;
    logic       busy;
    logic [7:0] alu_data;
    logic [1:0] opcode_value;
    logic       store_a;
    logic       store_b;
    logic       start;
    logic       alu_done;
    logic [7:0] result;
    logic       overflow_def;

    int vectors    = 0;
    int miscompares = 0;

    alu_controller #(
        .DATA_WIDTH    (8),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_opcode  (cmd_opcode),
        .cmd_a       (cmd_a),
        .cmd_b       (cmd_b),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_result  (rsp_result),
        .rsp_overflow(rsp_overflow),
        .rsp_error   (rsp_error),
        .busy        (busy),
        .alu_data    (alu_data),
        .opcode_value(opcode_value),
        .store_a     (store_a),
        .store_b     (store_b),
        .start       (start),
        .alu_done    (alu_done),
        .result      (result),
        .overflow_def(overflow_def)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %03b expected %03b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    // Present a command for one edge, then walk LOAD_A/LOAD_B/START and stop
    // in the first WAIT_DONE cycle (cycle 4 after acceptance).
    task automatic run_front(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        cmd_valid  = 1'b1;
        cmd_opcode = op;
        cmd_a      = a;
        cmd_b      = b;
        step();
        cmd_valid  = 1'b0;
        chk3("load_a_strobes", {store_a, store_b, start}, 3'b100);
        chk8("load_a_data", alu_data, a);
        chk2("load_a_opcode", opcode_value, op);
        chk1("load_a_cmd_ready", cmd_ready, 1'b0);
        chk1("load_a_busy", busy, 1'b1);
        step();
        chk3("load_b_strobes", {store_a, store_b, start}, 3'b010);
        chk8("load_b_data", alu_data, b);
        step();
        chk3("start_strobes", {store_a, store_b, start}, 3'b001);
        chk8("start_data", alu_data, 8'h00);
        step();
        chk3("wait_strobes", {store_a, store_b, start}, 3'b000);
        chk2("wait_opcode", opcode_value, op);
        chk1("wait_no_rsp", rsp_valid, 1'b0);
    endtask

    // Pulse alu_done for one cycle with the given datapath outputs and check
    // the captured response in the following cycle.
    task automatic finish_done(input logic [7:0] res, input logic ovf);
        alu_done     = 1'b1;
        result       = res;
        overflow_def = ovf;
        step();
        alu_done     = 1'b0;
        result       = 8'h00;
        overflow_def = 1'b0;
        chk1("rsp_valid", rsp_valid, 1'b1);
        chk8("rsp_result", rsp_result, res);
        chk1("rsp_overflow", rsp_overflow, ovf);
        chk1("rsp_error", rsp_error, 1'b0);
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk1("post_rsp_cmd_ready", cmd_ready, 1'b1);
        chk1("post_rsp_valid", rsp_valid, 1'b0);
    endtask

    initial begin
        reset        = 1'b1;
        cmd_valid    = 1'b0;
        cmd_opcode   = 2'b00;
        cmd_a        = 8'h00;
        cmd_b        = 8'h00;
        rsp_ready    = 1'b0;
        alu_done     = 1'b0;
        result       = 8'h00;
        overflow_def = 1'b0;
        repeat (2) step();
        reset = 1'b0;

        // Reset state
        chk1("rst_cmd_ready", cmd_ready, 1'b1);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_rsp_valid", rsp_valid, 1'b0);
        chk3("rst_strobes", {store_a, store_b, start}, 3'b000);
        chk8("rst_alu_data", alu_data, 8'h00);
        chk2("rst_opcode", opcode_value, 2'b00);
        chk8("rst_rsp_result", rsp_result, 8'h00);
        chk1("rst_rsp_overflow", rsp_overflow, 1'b0);
        chk1("rst_rsp_error", rsp_error, 1'b0);
        $display("reset: cmd_ready=%0b busy=%0b", cmd_ready, busy);

        // ADD 0F+01 = 10, done in cycle 4, response in cycle 5
        run_front(2'b00, 8'h0F, 8'h01);
        finish_done(8'h10, 1'b0);
        $display("ADD 0f+01 -> result=%02h ovf=%0b", rsp_result, rsp_overflow);
        handshake();

        // SUB 01-02 = FF with borrow; opcode held through a longer wait
        run_front(2'b01, 8'h01, 8'h02);
        for (int i = 0; i < 3; i++) begin
            step();
            chk2("sub_wait_opcode", opcode_value, 2'b01);
            chk1("sub_wait_no_rsp", rsp_valid, 1'b0);
        end
        finish_done(8'hFF, 1'b1);
        $display("SUB 01-02 -> result=%02h ovf=%0b", rsp_result, rsp_overflow);

        // Backpressure: hold rsp_ready low while a second command waits
        cmd_valid  = 1'b1;
        cmd_opcode = 2'b10;
        cmd_a      = 8'hA5;
        cmd_b      = 8'h3C;
        for (int i = 0; i < 3; i++) begin
            step();
            chk1("bp_rsp_valid", rsp_valid, 1'b1);
            chk8("bp_rsp_result", rsp_result, 8'hFF);
            chk1("bp_rsp_overflow", rsp_overflow, 1'b1);
            chk1("bp_cmd_ready", cmd_ready, 1'b0);
            chk3("bp_strobes", {store_a, store_b, start}, 3'b000);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk1("bp_idle_cmd_ready", cmd_ready, 1'b1);
        chk1("bp_idle_rsp_valid", rsp_valid, 1'b0);
        step();
        cmd_valid = 1'b0;
        chk3("bp_second_load_a", {store_a, store_b, start}, 3'b100);
        chk8("bp_second_data_a", alu_data, 8'hA5);
        chk2("bp_second_opcode", opcode_value, 2'b10);
        step();
        chk8("bp_second_data_b", alu_data, 8'h3C);
        step();
        chk1("bp_second_start", start, 1'b1);
        step();
        finish_done(8'h01, 1'b0);
        $display("PAR a5,3c -> result=%02h (after backpressure)", rsp_result);
        handshake();

        // Reset during WAIT_DONE aborts with no response; late done ignored
        run_front(2'b00, 8'h22, 8'h33);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk1("abort_cmd_ready", cmd_ready, 1'b1);
        chk1("abort_busy", busy, 1'b0);
        chk1("abort_rsp_valid", rsp_valid, 1'b0);
        chk8("abort_rsp_result", rsp_result, 8'h00);
        chk2("abort_opcode", opcode_value, 2'b00);
        chk3("abort_strobes", {store_a, store_b, start}, 3'b000);
        alu_done = 1'b1;
        result   = 8'h55;
        step();
        alu_done = 1'b0;
        result   = 8'h00;
        chk1("late_done_busy", busy, 1'b0);
        chk1("late_done_rsp_valid", rsp_valid, 1'b0);
        chk8("late_done_result", rsp_result, 8'h00);
        step();
        chk1("late_done_rsp_valid2", rsp_valid, 1'b0);
        $display("reset in WAIT_DONE -> busy=%0b rsp_valid=%0b", busy, rsp_valid);

        // Spurious done in IDLE, then held through LOAD_A
        alu_done = 1'b1;
        step();
        chk1("spur_idle_busy", busy, 1'b0);
        chk1("spur_idle_rsp_valid", rsp_valid, 1'b0);
        cmd_valid  = 1'b1;
        cmd_opcode = 2'b11;
        cmd_a      = 8'h40;
        cmd_b      = 8'h41;
        step();
        cmd_valid = 1'b0;
        chk3("spur_load_a", {store_a, store_b, start}, 3'b100);
        step();
        alu_done = 1'b0;
        chk3("spur_load_b", {store_a, store_b, start}, 3'b010);
        chk1("spur_load_b_rsp", rsp_valid, 1'b0);
        step();
        chk3("spur_start", {store_a, store_b, start}, 3'b001);
        step();
        chk1("spur_wait_rsp", rsp_valid, 1'b0);
        finish_done(8'h44, 1'b0);
        $display("COMP 40,41 -> result=%02h (spurious done ignored)", rsp_result);
        handshake();

`ifdef ALU_CTRL_TIMEOUT_EN
        // Timeout with no done: 16 waiting cycles (4..19), response in 20
        run_front(2'b00, 8'h01, 8'h01);
        repeat (15) step();
        chk1("to_before_expiry", rsp_valid, 1'b0);
        step();
        chk1("to_rsp_valid", rsp_valid, 1'b1);
        chk1("to_rsp_error", rsp_error, 1'b1);
        chk8("to_rsp_result", rsp_result, 8'h00);
        chk1("to_rsp_overflow", rsp_overflow, 1'b0);
        $display("timeout -> rsp_error=%0b result=%02h", rsp_error, rsp_result);
        handshake();

        // Done on the expiry cycle wins
        run_front(2'b00, 8'h01, 8'h01);
        repeat (15) step();
        finish_done(8'h02, 1'b0);
        $display("done on expiry -> rsp_error=%0b result=%02h", rsp_error, rsp_result);
        handshake();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_controller.md
# alu_controller

Sequencing controller for the 8-bit ALU datapath. It accepts one operation request (opcode plus two operands) over a valid/ready command interface and drives the datapath's load/start strobes in order. It waits for the datapath's completion, captures result and overflow, and returns them over a valid/ready response interface. It sits between the bus-side requester and the ALU datapath, and is the only agent that drives the datapath's control inputs.

## Interface
- DATA_WIDTH, 8, operand/result width; must match the datapath.
- TIMEOUT_CYCLES, 16, max cycles in WAIT_DONE before abort; only used with ALU_CTRL_TIMEOUT_EN.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  controller idle and able to accept.
- cmd_opcode  input  2  00 ADD, 01 SUB, 10 PAR, 11 COMP.
- cmd_a  input  DATA_WIDTH  operand A.
- cmd_b  input  DATA_WIDTH  operand B.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  requester accepts response.
- rsp_result  output  DATA_WIDTH  captured result.
- rsp_overflow  output  1  captured overflow/borrow.
- rsp_error  output  1  operation aborted by timeout.
- busy  output  1  high in any state other than IDLE.
- alu_data  output  DATA_WIDTH  operand bus to datapath.
- opcode_value  output  2  opcode to datapath.
- store_a, store_b, start  output  1 each  datapath strobes.
- alu_done  input  1  datapath completion.
- result  input  DATA_WIDTH  datapath result.
- overflow_def  input  1  datapath overflow.

## Operation
- States: IDLE, LOAD_A, LOAD_B, START, WAIT_DONE, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready, register opcode, A and B, then go to LOAD_A.
- LOAD_A: alu_data=A, store_a=1, then go to LOAD_B.
- LOAD_B: alu_data=B, store_b=1, then go to START.
- START: start=1 for exactly one cycle, then go to WAIT_DONE.
- Strobe exclusivity: at most one of store_a, store_b and start is high in any cycle.
- alu_data: 0 outside LOAD_A and LOAD_B.
- Opcode stability: opcode_value holds the registered opcode from LOAD_A through WAIT_DONE. The datapath's result mux depends on it while done is high.
- WAIT_DONE:
  - On alu_done=1, capture result into rsp_result and overflow_def into rsp_overflow, clear rsp_error, then go to RESP.
  - The capture must happen on that same edge, because the datapath zeroes result when done falls.
- alu_done outside WAIT_DONE is ignored.
- RESP:
  - rsp_valid=1 and response outputs held stable.
  - On rsp_ready, return to IDLE.
  - No new command is accepted until the next IDLE cycle; one operation is in flight at a time.
- Reset:
  - Values: state=IDLE; all strobes, alu_data, opcode_value, rsp_* and busy = 0; cmd_ready = 1 from the first cycle after reset.
  - Reset in any state aborts the operation with no response; the registered command is discarded.

## Timing
- Command accepted at edge 0.
- LOAD_A in cycle 1, LOAD_B in cycle 2, START in cycle 3, WAIT_DONE from cycle 4.
- If alu_done is first high in cycle N (N≥4), rsp_valid rises in cycle N+1.
- Minimum command-to-response latency is 5 cycles.
- If rsp_ready is high in the first RESP cycle, cmd_ready is high in the next cycle. Minimum throughput is one operation per 6 cycles.
- All outputs are registered or decoded from the state register only. There is no combinational path from cmd_* or rsp_ready to any datapath output.

## Configuration
- ALU_CTRL_TIMEOUT_EN defined:
  - A counter clears on entry to WAIT_DONE and increments each cycle there.
  - If it reaches TIMEOUT_CYCLES without alu_done, go to RESP with rsp_error=1, rsp_result=0, rsp_overflow=0.
  - If alu_done and expiry coincide, alu_done wins and rsp_error=0.
- ALU_CTRL_TIMEOUT_EN undefined:
  - No counter logic is compiled; WAIT_DONE waits indefinitely.
  - rsp_error is tied to 0 and TIMEOUT_CYCLES is ignored.

## Structure
- alu_ctrl_pkg holds:
  - opcode constants ADD/SUB/PAR/COMP (2'b00–2'b11);
  - the state enum typedef;
  - the default DATA_WIDTH and TIMEOUT_CYCLES.
- Sub-module alu_ctrl_timer holds the timeout counter (clear, enable, expired) and is instantiated only under ALU_CTRL_TIMEOUT_EN.
- FSM and response registers stay in alu_controller.

## Test plan
- ADD: A=8'h0F, B=8'h01, datapath model asserts done in cycle 4 → strobe order A/B/start in cycles 1/2/3; rsp_result=8'h10, rsp_overflow=0, rsp_valid in cycle 5.
- SUB borrow: A=8'h01, B=8'h02 → rsp_result=8'hFF, rsp_overflow=1; opcode_value=01 throughout WAIT_DONE.
- Backpressure: rsp_ready low for 3 cycles → rsp_* stable, cmd_ready=0 and a second cmd_valid is not accepted until after the handshake.
- Reset in WAIT_DONE → next cycle IDLE, all outputs 0, cmd_ready=1, no rsp_valid; a late alu_done is ignored.
- Timeout (macro on, TIMEOUT_CYCLES=16), done never asserted → rsp_valid with rsp_error=1, rsp_result=0. Done on the expiry cycle → rsp_error=0.
- Spurious alu_done pulse in IDLE or LOAD_A → no state change and no response.
